// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump engine.
package reg_dump_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] CSUM_IDX = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Dump sequencer: FSM, index counter and the registered handshake/status outputs.
// REG_DUMP_CHECKSUM_EN adds a trailing checksum beat after the last register.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
`ifdef REG_DUMP_CHECKSUM_EN
  output logic              o_start_c,
  output logic              o_csum_load_c,
`endif
  output logic              o_capture_c
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_valid, r_busy, r_done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic              r_csum, w_csum_nxt;
`endif

  // Next-state and strobe decode; abort overrides any handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_capture_c   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_nxt    = r_csum;
    o_start_c     = 1'b0;
    o_csum_load_c = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          o_start_c   = 1'b1;
`endif
        end
      end
      ST_READ: begin
        w_state_nxt = ST_SEND;
        o_capture_c = 1'b1;
      end
      ST_SEND: begin
        if (i_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          if (r_csum) begin
            w_state_nxt = ST_FINISH;
          end else if (r_cnt == LAST_IDX) begin
            w_csum_nxt    = 1'b1;
            o_csum_load_c = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + ADDR_W'(1);
            w_state_nxt = ST_READ;
          end
`else
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_cnt_nxt   = r_cnt + ADDR_W'(1);
            w_state_nxt = ST_READ;
          end
`endif
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      o_capture_c   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      o_csum_load_c = 1'b0;
`endif
    end

    // Returning to IDLE parks the read address at 0.
    if (w_state_nxt == ST_IDLE) begin
      w_cnt_nxt  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
      w_csum_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == ST_SEND);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FINISH);
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  assign o_cnt   = r_cnt;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/reg_dump.sv
// Register-file dump engine: streams NUM_REGS registers over a valid/ready port.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat at index 5'h1F.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [DATA_W-1:0] ReadData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done
);

  logic w_capture;
`ifdef REG_DUMP_CHECKSUM_EN
  logic              w_start;
  logic              w_csum_load;
  logic [DATA_W-1:0] r_acc;
`else
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`endif

  reg_dump_ctrl #(
    .NUM_REGS (NUM_REGS)
  ) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_start       (Start),
    .i_abort       (Abort),
    .i_ready       (OutReady),
    .o_cnt         (ReadRegister),
    .o_valid       (OutValid),
    .o_busy        (Busy),
    .o_done        (Done),
`ifdef REG_DUMP_CHECKSUM_EN
    .o_start_c     (w_start),
    .o_csum_load_c (w_csum_load),
`endif
    .o_capture_c   (w_capture)
  );

`ifdef REG_DUMP_CHECKSUM_EN
  // Running XOR of every captured register value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= r_acc ^ ReadData;
    end
  end

  // Beat payload: register data, or the checksum once the last register is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OutData  <= '0;
      OutIndex <= '0;
      OutLast  <= 1'b0;
    end else if (w_capture) begin
      OutData  <= ReadData;
      OutIndex <= ReadRegister;
      OutLast  <= 1'b0;
    end else if (w_csum_load) begin
      OutData  <= r_acc;
      OutIndex <= CSUM_IDX;
      OutLast  <= 1'b1;
    end
  end
`else
  // Beat payload captured in READ and held through any SEND stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OutData  <= '0;
      OutIndex <= '0;
      OutLast  <= 1'b0;
    end else if (w_capture) begin
      OutData  <= ReadData;
      OutIndex <= ReadRegister;
      OutLast  <= (ReadRegister == LAST_IDX);
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: full dumps, stalls, restart-ignore, abort and async reset.
module tb_reg_dump;

  localparam int NREG = 32;
  localparam int DW   = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          OutReady = 1'b0;
  logic [4:0]    ReadRegister;
  logic [DW-1:0] ReadData;
  logic          OutValid;
  logic [DW-1:0] OutData;
  logic [4:0]    OutIndex;
  logic          OutLast;
  logic          Busy;
  logic          Done;

  logic [DW-1:0] rf [NREG];
  assign ReadData = rf[ReadRegister];

  reg_dump #(.NUM_REGS(NREG), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .Abort        (Abort),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .OutData      (OutData),
    .OutIndex     (OutIndex),
    .OutLast      (OutLast),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    first_cyc = 0;
  int    start_cyc = 0;
  int    beats = 0;
  bit    first_seen = 1'b0;
  bit    pat_en = 1'b0;
  logic [1:0] pk = 2'd0;
  bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit    hold_pending = 1'b0;
  beat_t hold_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    beat_t         b;
    logic [DW-1:0] x;
    x = '0;
    for (int i = 0; i < NREG; i++) begin
      b.idx  = 5'(i);
      b.data = rf[i];
      b.last = (CS == 0) && (i == NREG - 1);
      q.push_back(b);
      x = x ^ rf[i];
    end
    if (CS != 0) begin
      b.idx  = 5'h1F;
      b.data = x;
      b.last = 1'b1;
      q.push_back(b);
    end
  endtask

  // Called at posedge+1: Start is sampled on the following edge.
  task automatic start_dump();
    push_dump();
    first_seen = 1'b0;
    start_cyc  = cyc;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    int n;
    n = 0;
    while (done_cnt < target && n < maxc) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_index(input logic [4:0] idx, input int maxc);
    int n;
    n = 0;
    while (!(OutValid && OutIndex == idx) && n < maxc) begin
      tick();
      n++;
    end
    check("reach_index", 64'(OutIndex), 64'(idx));
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (pat_en) begin
      #1;
      OutReady = pat[pk];
      pk++;
    end
  end

  // Monitor: handshake pops the scoreboard; stalled payload must hold.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (OutValid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (hold_pending && OutValid) begin
        check("hold_index", 64'(OutIndex), 64'(hold_b.idx));
        check("hold_data", 64'(OutData), 64'(hold_b.data));
        check("hold_last", 64'(OutLast), 64'(hold_b.last));
      end
      hold_pending = 1'b0;
      if (OutValid && !OutReady && !Abort) begin
        hold_pending = 1'b1;
        hold_b.idx   = OutIndex;
        hold_b.data  = OutData;
        hold_b.last  = OutLast;
      end
      if (OutValid && OutReady && !Abort) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check("beat_index", 64'(OutIndex), 64'(e.idx));
          check("beat_data", 64'(OutData), 64'(e.data));
          check("beat_last", 64'(OutLast), 64'(e.last));
          beats++;
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    int d0;
    for (int i = 0; i < NREG; i++) rf[i] = DW'(i) * 32'h0101_0101;

    // Reset state.
    repeat (3) tick();
    check("rst_valid", 64'(OutValid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_rdreg", 64'(ReadRegister), 64'd0);
    check("rst_index", 64'(OutIndex), 64'd0);
    check("rst_data", 64'(OutData), 64'd0);

    // Full dump, Start in the same cycle reset is released.
    reset    = 1'b0;
    OutReady = 1'b1;
    beats    = 0;
    start_dump();
    check("busy_during", 64'(Busy), 64'd1);
    wait_done(1, 300);
    check("first_valid_lat", 64'(first_cyc - start_cyc), 64'd2);
    check("done_lat", 64'(done_cyc - start_cyc), 64'(2 * NREG + 1 + CS));
    check("q_empty_full", 64'(q.size()), 64'd0);
    check("beats_full", 64'(beats), 64'(NREG + CS));
    tick();
    check("idle_busy", 64'(Busy), 64'd0);
    check("idle_valid", 64'(OutValid), 64'd0);
    check("idle_rdreg", 64'(ReadRegister), 64'd0);

    // Ready pattern 1,0,0,1 throughout.
    beats  = 0;
    pk     = 2'd0;
    pat_en = 1'b1;
    tick();
    start_dump();
    wait_done(2, 600);
    pat_en = 1'b0;
    tick();
    OutReady = 1'b1;
    check("q_empty_stall", 64'(q.size()), 64'd0);
    check("beats_stall", 64'(beats), 64'(NREG + CS));

    // Second Start at beat 5 is ignored.
    beats = 0;
    tick();
    start_dump();
    begin
      int n;
      n = 0;
      while (beats < 5 && n < 100) begin
        tick();
        n++;
      end
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(3, 300);
    repeat (10) tick();
    check("single_done", 64'(done_cnt), 64'd3);
    check("q_empty_restart", 64'(q.size()), 64'd0);
    check("beats_restart", 64'(beats), 64'(NREG + CS));
    check("restart_idle", 64'(Busy), 64'd0);

    // Abort while stalled at index 10 with ready on the same cycle.
    beats = 0;
    d0    = done_cnt;
    start_dump();
    wait_index(5'd10, 100);
    OutReady = 1'b0;
    tick();
    tick();
    check("stall_valid", 64'(OutValid), 64'd1);
    check("stall_index", 64'(OutIndex), 64'd10);
    Abort    = 1'b1;
    OutReady = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_valid", 64'(OutValid), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_beats", 64'(beats), 64'd10);
    q.delete();

    // Asynchronous reset mid-cycle at index 20.
    beats = 0;
    d0    = done_cnt;
    start_dump();
    wait_index(5'd20, 100);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(OutValid), 64'd0);
    check("arst_data", 64'(OutData), 64'd0);
    check("arst_index", 64'(OutIndex), 64'd0);
    check("arst_last", 64'(OutLast), 64'd0);
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_done", 64'(Done), 64'd0);
    check("arst_rdreg", 64'(ReadRegister), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    check("arst_no_done", 64'(done_cnt), 64'(d0));
    beats = 0;
    start_dump();
    wait_done(d0 + 1, 300);
    check("rerun_q_empty", 64'(q.size()), 64'd0);
    check("rerun_beats", 64'(beats), 64'(NREG + CS));
    check("rerun_done_lat", 64'(done_cyc - start_cyc), 64'(2 * NREG + 1 + CS));

`ifdef REG_DUMP_CHECKSUM_EN
    // Sparse register file: checksum beat carries the XOR.
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    rf[3] = 32'hA5A5_A5A5;
    rf[7] = 32'h0F0F_0F0F;
    beats = 0;
    d0    = done_cnt;
    tick();
    start_dump();
    wait_done(d0 + 1, 300);
    check("csum_q_empty", 64'(q.size()), 64'd0);
    check("csum_beats", 64'(beats), 64'(NREG + 1));
    check("csum_data", 64'(OutData), 64'hAAAA_AAAA);
    check("csum_index", 64'(OutIndex), 64'h1F);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
